// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// The arbiter uses the slave modport; the environment (requesters plus memory) uses master.
interface dmem_arbiter_if #(
    parameter int XLEN     = 32,
    parameter int FUNCT3_W = 3
);
    // m0: core load/store path
    logic                m0_req;
    logic                m0_we;
    logic [FUNCT3_W-1:0] m0_funct3;
    logic [XLEN-1:0]     m0_addr;
    logic [XLEN-1:0]     m0_wdata;
    logic                m0_gnt;
    logic                m0_rvalid;
    logic [XLEN-1:0]     m0_rdata;
    logic                m0_err;

    // m1: debug/DMA port, with burst lock request
    logic                m1_req;
    logic                m1_we;
    logic [FUNCT3_W-1:0] m1_funct3;
    logic [XLEN-1:0]     m1_addr;
    logic [XLEN-1:0]     m1_wdata;
    logic                m1_lock;
    logic                m1_gnt;
    logic                m1_rvalid;
    logic [XLEN-1:0]     m1_rdata;
    logic                m1_err;

    // memory side
    logic                mem_read;
    logic                mem_write;
    logic [FUNCT3_W-1:0] mem_funct3;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN-1:0]     mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_funct3, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_funct3, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_read, mem_write, mem_funct3, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_funct3, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_funct3, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_read, mem_write, mem_funct3, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory.
// IDLE/RESP sample requests, ACCESS drives memory for one cycle, RESP returns the
// registered response. Round-robin between m0 and m1, with a bounded lock for m1.
module dmem_arbiter #(
    parameter int XLEN     = 32,
    parameter int FUNCT3_W = 3,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_reg;
    logic [1:0]          gnt_reg;
    logic [1:0]          rvalid_reg;
    logic [1:0]          err_reg;
    logic [XLEN-1:0]     m0_rdata_reg;
    logic [XLEN-1:0]     m1_rdata_reg;
    logic                mem_read_reg;
    logic                mem_write_reg;
    logic                cmd_we_reg;
    logic [FUNCT3_W-1:0] cmd_funct3_reg;
    logic [XLEN-1:0]     cmd_addr_reg;
    logic [XLEN-1:0]     cmd_wdata_reg;
    logic                cmd_err_reg;
    logic                last_m1_reg;   // 1 = m1 won the last arbitration (rr pointer)
    logic                lock_last_reg; // m1_lock as seen at the last m1 grant
    logic [CNT_W-1:0]    lock_cnt_reg;

    logic                any_req;
    logic                lock_win;
    logic                pick_m1;
    logic                sel_we;
    logic [FUNCT3_W-1:0] sel_funct3;
    logic [XLEN-1:0]     sel_addr;
    logic [XLEN-1:0]     sel_wdata;
    logic                sel_err;
    logic [XLEN-1:0]     rsp_data;

    // Illegal size code or misaligned address: the access is answered with err and never reaches memory.
    function automatic logic access_err(input logic we, input logic [FUNCT3_W-1:0] f3,
                                        input logic [XLEN-1:0] addr);
        logic bad_code;
        logic bad_align;
        bad_code  = 1'b0;
        bad_align = 1'b0;
        if (we) begin
            bad_code = !(f3 == FUNCT3_W'(0) || f3 == FUNCT3_W'(1) || f3 == FUNCT3_W'(2));
        end else begin
            bad_code = !(f3 == FUNCT3_W'(0) || f3 == FUNCT3_W'(1) || f3 == FUNCT3_W'(2) ||
                         f3 == FUNCT3_W'(4) || f3 == FUNCT3_W'(5));
        end
        case (f3[1:0])
            2'b01:   bad_align = addr[0];
            2'b10:   bad_align = |addr[1:0];
            default: bad_align = 1'b0;
        endcase
        return bad_code | bad_align;
    endfunction

    // Winner selection and command mux for the arbitration cycle.
    always_comb begin
        any_req  = bus.m0_req | bus.m1_req;
        lock_win = last_m1_reg & lock_last_reg & bus.m1_req & (lock_cnt_reg < CNT_W'(LOCK_MAX));
        pick_m1  = bus.m1_req & (!bus.m0_req | lock_win | !last_m1_reg);
        if (pick_m1) begin
            sel_we     = bus.m1_we;
            sel_funct3 = bus.m1_funct3;
            sel_addr   = bus.m1_addr;
            sel_wdata  = bus.m1_wdata;
        end else begin
            sel_we     = bus.m0_we;
            sel_funct3 = bus.m0_funct3;
            sel_addr   = bus.m0_addr;
            sel_wdata  = bus.m0_wdata;
        end
        sel_err  = access_err(sel_we, sel_funct3, sel_addr);
        rsp_data = (!cmd_we_reg && !cmd_err_reg) ? bus.mem_rdata : '0;
    end

    // Control FSM with registered grant/response/strobe outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            gnt_reg        <= '0;
            rvalid_reg     <= '0;
            err_reg        <= '0;
            m0_rdata_reg   <= '0;
            m1_rdata_reg   <= '0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            cmd_we_reg     <= 1'b0;
            cmd_funct3_reg <= '0;
            cmd_addr_reg   <= '0;
            cmd_wdata_reg  <= '0;
            cmd_err_reg    <= 1'b0;
            last_m1_reg    <= 1'b1; // m0 wins the first contended arbitration
            lock_last_reg  <= 1'b0;
            lock_cnt_reg   <= '0;
        end else begin
            gnt_reg       <= '0;
            rvalid_reg    <= '0;
            err_reg       <= '0;
            m0_rdata_reg  <= '0;
            m1_rdata_reg  <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            case (state_reg)
                IDLE, RESP: begin
                    if (any_req) begin
                        cmd_we_reg     <= sel_we;
                        cmd_funct3_reg <= sel_funct3;
                        cmd_addr_reg   <= sel_addr;
                        cmd_wdata_reg  <= sel_wdata;
                        cmd_err_reg    <= sel_err;
                        mem_read_reg   <= !sel_we && !sel_err;
                        mem_write_reg  <= sel_we && !sel_err;
                        gnt_reg        <= pick_m1 ? 2'b10 : 2'b01;
                        last_m1_reg    <= pick_m1;
                        if (pick_m1) begin
                            lock_last_reg <= bus.m1_lock;
                            if (!bus.m1_lock) begin
                                lock_cnt_reg <= '0;
                            end else if (lock_win && bus.m0_req) begin
                                lock_cnt_reg <= lock_cnt_reg + CNT_W'(1);
                            end
                        end else begin
                            lock_last_reg <= 1'b0;
                            lock_cnt_reg  <= '0;
                        end
                        state_reg <= ACCESS;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                ACCESS: begin
                    if (last_m1_reg) begin
                        rvalid_reg[1] <= 1'b1;
                        err_reg[1]    <= cmd_err_reg;
                        m1_rdata_reg  <= rsp_data;
                    end else begin
                        rvalid_reg[0] <= 1'b1;
                        err_reg[0]    <= cmd_err_reg;
                        m0_rdata_reg  <= rsp_data;
                    end
                    state_reg <= RESP;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.m0_gnt    = gnt_reg[0];
    assign bus.m1_gnt    = gnt_reg[1];
    assign bus.m0_rvalid = rvalid_reg[0];
    assign bus.m1_rvalid = rvalid_reg[1];
    assign bus.m0_err    = err_reg[0];
    assign bus.m1_err    = err_reg[1];
    assign bus.m0_rdata  = m0_rdata_reg;
    assign bus.m1_rdata  = m1_rdata_reg;

    // Reset wins over an in-flight strobe in the same cycle.
    assign bus.mem_read   = mem_read_reg & !reset;
    assign bus.mem_write  = mem_write_reg & !reset;
    assign bus.mem_funct3 = cmd_funct3_reg;
    assign bus.mem_addr   = cmd_addr_reg;
    assign bus.mem_wdata  = cmd_wdata_reg;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: single accesses, error rejection,
// round-robin and lock ordering, and reset during an access.
module tb_dmem_arbiter;
    localparam int XLEN     = 32;
    localparam int FUNCT3_W = 3;
    localparam int LOCK_MAX = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dmem_arbiter_if #(.XLEN(XLEN), .FUNCT3_W(FUNCT3_W)) bus ();

    dmem_arbiter #(.XLEN(XLEN), .FUNCT3_W(FUNCT3_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] rdata;
        logic            err;
    } rsp_t;

    rsp_t rsp_q[$];
    int   grant_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_funct3 = '0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_funct3 = '0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.m1_lock = 0;
        bus.mem_rdata = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One complete single-requester transaction, checked from request to response.
    task automatic run_access(input int m, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mem_val, input logic exp_err, input string name);
        logic got;
        int   waited;
        rsp_t exp;
        rsp_t act;
        logic exp_rd;
        logic exp_wr;
        bus.mem_rdata = mem_val;
        if (m == 0) begin
            bus.m0_req = 1; bus.m0_we = we; bus.m0_funct3 = f3; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = 1; bus.m1_we = we; bus.m1_funct3 = f3; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end
        got = 0;
        waited = 0;
        while (!got && waited < 8) begin
            tick();
            waited++;
            got = (m == 0) ? bus.m0_gnt : bus.m1_gnt;
        end
        n_checks++;
        if (!got || waited != 1) begin
            n_fail++;
            $display("FAIL %s gnt_latency: got %0d cycles (granted=%0b), required 1", name, waited, got);
        end
        bus.m0_req = 0;
        bus.m1_req = 0;
        if (!got) return;
        exp_rd = !we && !exp_err;
        exp_wr = we && !exp_err;
        n_checks++;
        if ({bus.mem_read, bus.mem_write} !== {exp_rd, exp_wr}) begin
            n_fail++;
            $display("FAIL %s strobes: read/write=%0b%0b, required %0b%0b",
                     name, bus.mem_read, bus.mem_write, exp_rd, exp_wr);
        end
        n_checks++;
        if (bus.mem_addr !== addr || bus.mem_funct3 !== f3 || bus.mem_wdata !== wdata) begin
            n_fail++;
            $display("FAIL %s mem_bus: addr=%h f3=%0d wdata=%h, required addr=%h f3=%0d wdata=%h",
                     name, bus.mem_addr, bus.mem_funct3, bus.mem_wdata, addr, f3, wdata);
        end
        exp.rdata = (we || exp_err) ? 32'h0 : mem_val;
        exp.err   = exp_err;
        rsp_q.push_back(exp);
        tick();
        got = (m == 0) ? bus.m0_rvalid : bus.m1_rvalid;
        act.rdata = (m == 0) ? bus.m0_rdata : bus.m1_rdata;
        act.err   = (m == 0) ? bus.m0_err : bus.m1_err;
        exp = rsp_q.pop_front();
        n_checks++;
        if (!got || act.rdata !== exp.rdata || act.err !== exp.err) begin
            n_fail++;
            $display("FAIL %s response: rvalid=%0b rdata=%h err=%0b, required rvalid=1 rdata=%h err=%0b",
                     name, got, act.rdata, act.err, exp.rdata, exp.err);
        end
        n_checks++;
        if (((m == 0) ? bus.m1_rvalid : bus.m0_rvalid) || bus.mem_read || bus.mem_write) begin
            n_fail++;
            $display("FAIL %s resp_quiet: other_rvalid/read/write=%0b%0b%0b, required 000", name,
                     (m == 0) ? bus.m1_rvalid : bus.m0_rvalid, bus.mem_read, bus.mem_write);
        end
        $display("txn %s: m%0d we=%0b f3=%0d addr=%h rdata=%h err=%0b", name, m, we, f3, addr,
                 act.rdata, act.err);
        tick();
    endtask

    // Both masters request continuously; grant order is checked against grant_q.
    task automatic run_contention(input logic lock, input int n_grants, input string name);
        int cyc;
        int last;
        int seen;
        int who;
        int exp_who;
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_funct3 = 3'b010; bus.m0_addr = 32'h100;
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_funct3 = 3'b010; bus.m1_addr = 32'h200;
        bus.m1_lock = lock;
        cyc = 0; last = -1; seen = 0;
        while (seen < n_grants && cyc < 4 * n_grants + 10) begin
            tick();
            cyc++;
            if (bus.m0_gnt && bus.m1_gnt) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s simultaneous_gnt: both grants high at cycle %0d, required one", name, cyc);
            end else if (bus.m0_gnt || bus.m1_gnt) begin
                who = bus.m1_gnt ? 1 : 0;
                exp_who = grant_q.pop_front();
                n_checks++;
                if (who != exp_who) begin
                    n_fail++;
                    $display("FAIL %s grant_order: grant %0d went to m%0d, required m%0d", name, seen, who, exp_who);
                end
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last != 2) begin
                        n_fail++;
                        $display("FAIL %s grant_spacing: %0d cycles, required 2", name, cyc - last);
                    end
                end
                $display("txn %s: grant %0d to m%0d at cycle %0d", name, seen, who, cyc);
                last = cyc;
                seen++;
                if (seen == n_grants) begin
                    bus.m0_req = 0;
                    bus.m1_req = 0;
                end
            end
        end
        n_checks++;
        if (seen != n_grants) begin
            n_fail++;
            $display("FAIL %s grant_count: saw %0d grants, required %0d", name, seen, n_grants);
        end
        drive_idle();
        grant_q.delete();
        tick();
        tick();
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err,
             bus.mem_read, bus.mem_write} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt/rvalid/err/strobes=%b, required 00000000",
                     {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err,
                      bus.mem_read, bus.mem_write});
        end
        n_checks++;
        if ((bus.m0_rdata | bus.m1_rdata | bus.mem_addr | bus.mem_wdata) !== 32'h0 || bus.mem_funct3 !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_data: rdata0=%h rdata1=%h addr=%h wdata=%h f3=%0d, required all 0",
                     bus.m0_rdata, bus.m1_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_funct3);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.mem_read, bus.mem_write} !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_idle: gnt/strobes=%b with no request, required 0000",
                     {bus.m0_gnt, bus.m1_gnt, bus.mem_read, bus.mem_write});
        end
        $display("txn reset: outputs idle");
    endtask

    task automatic test_load_word();
        run_access(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_m0");
        run_access(1, 1'b0, 3'b101, 32'h42, 32'h0, 32'h0000_8001, 1'b0, "lhu_m1");
    endtask

    task automatic test_misaligned();
        run_access(0, 1'b1, 3'b001, 32'h3, 32'h1234, 32'h5555_5555, 1'b1, "sh_misaligned");
        run_access(0, 1'b0, 3'b010, 32'h6, 32'h0, 32'h6666_6666, 1'b1, "lw_misaligned");
    endtask

    task automatic test_illegal_funct3();
        run_access(0, 1'b0, 3'b011, 32'h8, 32'h0, 32'h7777_7777, 1'b1, "load_f3_011");
        run_access(0, 1'b1, 3'b100, 32'h8, 32'hFF, 32'h0, 1'b1, "store_f3_100");
        run_access(0, 1'b0, 3'b100, 32'h7, 32'h0, 32'h0000_00C3, 1'b0, "lbu_odd");
    endtask

    task automatic test_store_byte();
        run_access(0, 1'b1, 3'b000, 32'h5, 32'hAB, 32'h9999_9999, 1'b0, "sb_m0");
        run_access(1, 1'b1, 3'b010, 32'h24, 32'hCAFE_F00D, 32'h0, 1'b0, "sw_m1");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        grant_q = '{0, 1, 0, 1};
        run_contention(1'b0, 4, "rr");
    endtask

    task automatic test_lock();
        apply_reset();
        // m0 first (reset rr), m1 by rr then 4 locked grants, m0, repeat to show the count clears
        grant_q = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
        run_contention(1'b1, 13, "lock");
    endtask

    task automatic test_reset_mid_access();
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_funct3 = 3'b010;
        bus.m1_addr = 32'h20; bus.m1_wdata = 32'h1234_5678;
        tick();
        n_checks++;
        if (bus.m1_gnt !== 1'b1 || bus.mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_access: m1_gnt=%0b mem_write=%0b, required 1 1", bus.m1_gnt, bus.mem_write);
        end
        reset = 1'b1;
        bus.m1_req = 0;
        #1;
        n_checks++;
        if (bus.mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_write: mem_write=%0b with reset asserted, required 0", bus.mem_write);
        end
        tick();
        n_checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_read, bus.mem_write} !== 6'h0 ||
            bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_clear: ctrl=%b addr=%h wdata=%h, required 0",
                     {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_read, bus.mem_write},
                     bus.mem_addr, bus.mem_wdata);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (bus.m1_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_rvalid: m1_rvalid=%0b after reset, required 0", bus.m1_rvalid);
        end
        $display("txn midrst: m1 sw dropped by reset");
        grant_q = '{0, 1};
        run_contention(1'b0, 2, "post_reset");
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_misaligned();
        test_illegal_funct3();
        test_store_byte();
        test_back_to_back();
        test_lock();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates two requesters onto the single-port data memory: m0 is the core load/store path, m1 is the debug/DMA port.
- Latches the winning command, drives the memory for exactly one cycle, then returns a registered response.
- Rejects misaligned accesses and illegal funct3 codes before any memory access.
- Supports a bounded burst lock on m1.

Parameters:
XLEN, 32, data/address width
FUNCT3_W, 3, width of the funct3 access-size field
LOCK_MAX, 4, maximum consecutive m1 grants under lock while m0 is waiting (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m0_req  in  1  m0 request; held until m0_gnt
m0_we  in  1  1=store, 0=load
m0_funct3  in  FUNCT3_W  access size/sign (RV32 load/store encoding)
m0_addr  in  XLEN  byte address
m0_wdata  in  XLEN  store data
m0_gnt  out  1  one-cycle grant pulse
m0_rvalid  out  1  one-cycle response pulse
m0_rdata  out  XLEN  load data, valid with m0_rvalid
m0_err  out  1  access rejected, valid with m0_rvalid
m1_req, m1_we, m1_funct3, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err  same as m0
m1_lock  in  1  request to keep ownership for the next access
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_funct3  out  FUNCT3_W  to memory funct3
mem_addr  out  XLEN  to memory addr
mem_wdata  out  XLEN  to memory write_data
mem_rdata  in  XLEN  combinational memory read data

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Requests are sampled only in IDLE and RESP.
- Arbitration, in IDLE or RESP with any req:
  - Pick a winner; latch its we, funct3, addr, wdata and the err flag; go to ACCESS.
  - In RESP with no req, go to IDLE.
- Winner selection:
  - Single requester wins.
  - Both requesting: the one not granted last (rr pointer).
  - Lock override: if m1 won last, m1_lock was high at that grant, m1_req=1, and lock_cnt<LOCK_MAX, m1 wins regardless of rr.
  - lock_cnt increments on each locked m1 grant made while m0_req=1.
  - lock_cnt clears on any m0 grant or any m1 grant with m1_lock=0.
- ACCESS (always 1 cycle):
  - mx_gnt=1 for the winner.
  - mem_read = !we & !err; mem_write = we & !err.
  - mem_funct3/addr/wdata are driven from the latched registers.
  - Capture mem_rdata into the response register if the access is a load with err=0; otherwise capture 0.
  - Go to RESP.
- RESP:
  - mx_rvalid=1 for the winner with mx_rdata and mx_err.
  - Stores also receive rvalid as an acknowledgement, with rdata=0.
- Error conditions (no memory strobe issued):
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- Latency: request sampled in cycle N -> gnt and memory strobe in N+1 -> rvalid in N+2. Peak throughput is one access per 2 cycles.
- Requester rule: deassert or update req in the cycle after gnt.
  - req is ignored while in ACCESS.
  - A req still held in RESP is treated as a new request.
- Outputs:
  - gnt and rvalid are registered pulses; never both asserted for both masters in the same cycle.
  - mem_* strobes are 0 outside ACCESS.
  - Address/data outputs hold their last latched value.
- Reset (any state, including mid-ACCESS):
  - Next state IDLE; every output 0; latched command, response registers and lock_cnt cleared.
  - rr pointer is set so m0 wins the first contended arbitration.
  - In-flight access is dropped with no rvalid.
  - Reset asserted during ACCESS suppresses mem_write in that cycle (reset has priority).

Test Plan:
- m0 LW addr=0x10 with mem_rdata=0xDEADBEEF -> m0_gnt @N+1 with mem_read=1, mem_addr=0x10; m0_rvalid @N+2 with rdata=0xDEADBEEF, err=0.
- m0 and m1 request in the same cycle out of reset, both held continuously -> grant order m0, m1, m0, m1; gnt pulses 2 cycles apart; never simultaneous.
- m1_lock=1 with m1 and m0 both requesting continuously, LOCK_MAX=4 -> m1 wins the first grant plus 4 locked grants, then m0 is granted; lock_cnt returns to 0.
- m0 SH addr=0x3, then LW addr=0x6 -> no mem_read/mem_write; each rvalid has err=1, rdata=0.
- Load funct3=011 -> err=1 with no strobe. SB funct3=000, addr=0x5, wdata=0xAB -> mem_write=1, mem_funct3=000, rvalid err=0.
- Reset asserted in the ACCESS cycle of an m1 SW -> mem_write=0 that cycle; no m1_rvalid; all outputs 0; next contended request grants m0.
